// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet packet generator: frame types,
// header/minimum-length constants, send-request codes and frame length rule.
package eth_pkg;

  typedef enum logic {
    PKT_ARP = 1'b0,
    PKT_UDP = 1'b1
  } pkt_type_t;

  localparam logic [15:0] ETH_MIN_FRAME  = 16'd60;
  localparam logic [15:0] ETH_IP_UDP_HDR = 16'd42;

  localparam logic [1:0] SEND_NONE = 2'd0;
  localparam logic [1:0] SEND_ARP  = 2'd1;
  localparam logic [1:0] SEND_UDP  = 2'd2;
  localparam logic [1:0] SEND_BOTH = 2'd3;

  // Frame length in bytes excluding FCS; short frames are padded to the
  // Ethernet minimum. Callers guarantee udp_len is small enough not to wrap.
  function automatic logic [15:0] frame_len(input pkt_type_t ptype,
                                            input logic [15:0] udp_len);
    logic [15:0] len;
    if (ptype == PKT_ARP) begin
      len = ETH_MIN_FRAME;
    end else begin
      len = ETH_IP_UDP_HDR + udp_len;
      if (len < ETH_MIN_FRAME) begin
        len = ETH_MIN_FRAME;
      end
    end
    return len;
  endfunction

endpackage

// File: rtl/eth_tx_scheduler.sv
// Frame transmit scheduler: latches ARP/UDP send requests, grants them one at
// a time to the frame builder (ARP first), enforces the inter-frame gap and a
// completion timeout, and keeps per-type sent counters and sticky error flags.
module eth_tx_scheduler
  import eth_pkg::*;
#(
  parameter int unsigned IFG_CLKS     = 12,
  parameter int unsigned TIMEOUT_CLKS = 65535,
  parameter int unsigned MAX_UDP_LEN  = 1472
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  i_send_packet,
  input  logic [15:0] i_udp_data_len,
  input  logic        i_tx_ready,
  input  logic        i_tx_done,
  input  logic        i_clr_status,
  output logic        o_tx_start,
  output logic        o_tx_type,
  output logic [15:0] o_frame_len,
  output logic        o_busy,
  output logic [15:0] o_arp_cnt,
  output logic [15:0] o_udp_cnt,
  output logic        o_err_len,
  output logic        o_err_timeout
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        arp_pend_q, arp_pend_d;
  logic        udp_pend_q, udp_pend_d;
  // Shared cycle counter: timeout count in WAIT_DONE, gap count in GAP.
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic        tx_start_q, tx_start_d;
  pkt_type_t   tx_type_q, tx_type_d;
  logic [15:0] frame_len_q, frame_len_d;
  logic        busy_q;
  logic [15:0] arp_cnt_q, arp_cnt_d;
  logic [15:0] udp_cnt_q, udp_cnt_d;
  logic        err_len_q, err_len_d;
  logic        err_to_q, err_to_d;

  logic req_arp, req_udp, udp_too_long;
  logic arp_clr, udp_clr, done_evt, timeout_evt, drop_evt;

  assign req_arp      = (i_send_packet == SEND_ARP) || (i_send_packet == SEND_BOTH);
  assign req_udp      = (i_send_packet == SEND_UDP) || (i_send_packet == SEND_BOTH);
  assign udp_too_long = ({16'd0, i_udp_data_len} > MAX_UDP_LEN);

  // Sequencing: grant selection in IDLE, start pulse, done/timeout wait, gap.
  always_comb begin
    state_d     = state_q;
    cyc_cnt_d   = cyc_cnt_q;
    tx_start_d  = 1'b0;
    tx_type_d   = tx_type_q;
    frame_len_d = frame_len_q;
    arp_clr     = 1'b0;
    udp_clr     = 1'b0;
    done_evt    = 1'b0;
    timeout_evt = 1'b0;
    drop_evt    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_tx_ready) begin
          if (arp_pend_q) begin
            arp_clr     = 1'b1;
            tx_type_d   = PKT_ARP;
            frame_len_d = frame_len(PKT_ARP, i_udp_data_len);
            tx_start_d  = 1'b1;
            state_d     = START;
          end else if (udp_pend_q) begin
            udp_clr = 1'b1;
            if (udp_too_long) begin
              // Oversized payload is discarded without involving the builder.
              drop_evt = 1'b1;
            end else begin
              tx_type_d   = PKT_UDP;
              frame_len_d = frame_len(PKT_UDP, i_udp_data_len);
              tx_start_d  = 1'b1;
              state_d     = START;
            end
          end
        end
      end
      START: begin
        cyc_cnt_d = '0;
        state_d   = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_tx_done) begin
          done_evt  = 1'b1;
          cyc_cnt_d = '0;
          state_d   = GAP;
        end else if (cyc_cnt_q == TIMEOUT_CLKS - 1) begin
          timeout_evt = 1'b1;
          cyc_cnt_d   = '0;
          state_d     = GAP;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 32'd1;
        end
      end
      GAP: begin
        if (cyc_cnt_q == IFG_CLKS - 1) begin
          state_d = IDLE;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending flags merge repeats; a new request beats a same-cycle grant clear.
  always_comb begin
    arp_pend_d = (arp_pend_q && !arp_clr) || req_arp;
    udp_pend_d = (udp_pend_q && !udp_clr) || req_udp;
  end

  // Status: counters and sticky errors, with clear taking precedence.
  always_comb begin
    arp_cnt_d = arp_cnt_q;
    udp_cnt_d = udp_cnt_q;
    err_len_d = err_len_q;
    err_to_d  = err_to_q;
    if (i_clr_status) begin
      arp_cnt_d = '0;
      udp_cnt_d = '0;
      err_len_d = 1'b0;
      err_to_d  = 1'b0;
    end else begin
      if (done_evt && (tx_type_q == PKT_ARP)) arp_cnt_d = arp_cnt_q + 16'd1;
      if (done_evt && (tx_type_q == PKT_UDP)) udp_cnt_d = udp_cnt_q + 16'd1;
      if (drop_evt)    err_len_d = 1'b1;
      if (timeout_evt) err_to_d  = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      arp_pend_q  <= 1'b0;
      udp_pend_q  <= 1'b0;
      cyc_cnt_q   <= '0;
      tx_start_q  <= 1'b0;
      tx_type_q   <= PKT_ARP;
      frame_len_q <= '0;
      busy_q      <= 1'b0;
      arp_cnt_q   <= '0;
      udp_cnt_q   <= '0;
      err_len_q   <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      arp_pend_q  <= arp_pend_d;
      udp_pend_q  <= udp_pend_d;
      cyc_cnt_q   <= cyc_cnt_d;
      tx_start_q  <= tx_start_d;
      tx_type_q   <= tx_type_d;
      frame_len_q <= frame_len_d;
      busy_q      <= (state_d != IDLE);
      arp_cnt_q   <= arp_cnt_d;
      udp_cnt_q   <= udp_cnt_d;
      err_len_q   <= err_len_d;
      err_to_q    <= err_to_d;
    end
  end

  assign o_tx_start    = tx_start_q;
  assign o_tx_type     = tx_type_q;
  assign o_frame_len   = frame_len_q;
  assign o_busy        = busy_q;
  assign o_arp_cnt     = arp_cnt_q;
  assign o_udp_cnt     = udp_cnt_q;
  assign o_err_len     = err_len_q;
  assign o_err_timeout = err_to_q;

endmodule
